// File: rtl/kmeans_classify_core.sv
// kmeans_classify_core
// Three-stage nearest-centroid classifier with per-cluster saturating
// coordinate sums and counts for the following centroid update.
//
// Handshake: a point is taken on any cycle with pt_valid && pt_ready.
// pt_ready is simply !cen_load, so a centroid write and a point acceptance
// never share a cycle. Nothing downstream can stall, so an accepted point
// always reaches S3 three cycles later unless rst intervenes.
module kmeans_classify_core #(
    parameter int NUM_CENTROIDS = 8,
    parameter int DIMS          = 7,
    parameter int COORD_W       = 13,
    parameter int ACCUM_W       = 22,
    parameter int CNT_W         = 10,
    parameter int DIST_MODE     = 0,
    localparam int IDX_W  = (NUM_CENTROIDS > 2) ? $clog2(NUM_CENTROIDS) : 1,
    localparam int DIST_W = ((DIST_MODE == 1) ? 2 * COORD_W : COORD_W) + $clog2(DIMS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IDX_W:0]            k_active,
    input  logic                      cen_load,
    input  logic [IDX_W-1:0]          cen_idx,
    input  logic [DIMS*COORD_W-1:0]   cen_data,
    input  logic                      pt_valid,
    output logic                      pt_ready,
    input  logic [DIMS*COORD_W-1:0]   pt_data,
    input  logic                      accum_clear,
    output logic                      label_valid,
    output logic [IDX_W-1:0]          label,
    output logic [DIST_W-1:0]         min_dist,
    input  logic [IDX_W-1:0]          rd_idx,
    output logic [DIMS*ACCUM_W-1:0]   rd_sum,
    output logic [CNT_W-1:0]          rd_cnt,
    output logic                      busy,
    output logic                      ovf,
    output logic                      cen_err
);

    logic [DIMS*COORD_W-1:0] cen_q [NUM_CENTROIDS];

    logic                    s1_v;
    logic                    s2_v;
    logic [DIMS*COORD_W-1:0] s1_pt;
    logic [DIMS*COORD_W-1:0] s2_pt;
    logic [DIMS*COORD_W-1:0] s3_pt;

    logic [DIST_W-1:0] dist_d [NUM_CENTROIDS];
    logic [DIST_W-1:0] dist_q [NUM_CENTROIDS];

    logic [IDX_W:0]    k_eff;
    logic [IDX_W-1:0]  best_idx;
    logic [DIST_W-1:0] best_dist;

    logic [ACCUM_W-1:0] sum_q   [NUM_CENTROIDS][DIMS];
    logic [CNT_W-1:0]   cnt_q   [NUM_CENTROIDS];
    logic [ACCUM_W-1:0] sum_nxt [DIMS];
    logic [CNT_W-1:0]   cnt_nxt;
    logic               sat_any;

    logic accept;

    assign pt_ready = !cen_load;
    assign accept   = pt_valid && pt_ready;
    assign busy     = s1_v | s2_v | label_valid;

    // Centroid slots: writes are dropped and flagged while points are in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CENTROIDS; i++) cen_q[i] <= '0;
            cen_err <= 1'b0;
        end else if (cen_load) begin
            if (busy) cen_err <= 1'b1;
            else      cen_q[cen_idx] <= cen_data;
        end
    end

    // S1: capture the accepted point
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v  <= 1'b0;
            s1_pt <= '0;
        end else begin
            s1_v <= accept;
            if (accept) s1_pt <= pt_data;
        end
    end

    // Exact distance from the S1 point to every centroid slot
    always_comb begin
        logic [COORD_W-1:0] p;
        logic [COORD_W-1:0] c;
        logic [COORD_W-1:0] diff;
        logic [DIST_W-1:0]  term;
        p    = '0;
        c    = '0;
        diff = '0;
        term = '0;
        for (int i = 0; i < NUM_CENTROIDS; i++) begin
            dist_d[i] = '0;
            for (int d = 0; d < DIMS; d++) begin
                p    = s1_pt[d*COORD_W +: COORD_W];
                c    = cen_q[i][d*COORD_W +: COORD_W];
                diff = (p > c) ? (p - c) : (c - p);
                term = DIST_W'(diff);
                if (DIST_MODE == 1) term = term * term;
                dist_d[i] = dist_d[i] + term;
            end
        end
    end

    // S2: register all distances alongside the point
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v <= 1'b0;
        end else begin
            s2_v <= s1_v;
        end
        if (s1_v) begin
            s2_pt <= s1_pt;
            for (int i = 0; i < NUM_CENTROIDS; i++) dist_q[i] <= dist_d[i];
        end
    end

    // Argmin over active slots; strict compare keeps the lowest index on ties
    always_comb begin
        k_eff = k_active;
        if (k_active == '0)
            k_eff = (IDX_W+1)'(1);
        else if (k_active > (IDX_W+1)'(NUM_CENTROIDS))
            k_eff = (IDX_W+1)'(NUM_CENTROIDS);
        best_idx  = '0;
        best_dist = dist_q[0];
        for (int i = 1; i < NUM_CENTROIDS; i++) begin
            if (((IDX_W+1)'(i) < k_eff) && (dist_q[i] < best_dist)) begin
                best_idx  = IDX_W'(i);
                best_dist = dist_q[i];
            end
        end
    end

    // S3: register the result; label/min_dist hold between strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            label_valid <= 1'b0;
            label       <= '0;
            min_dist    <= '0;
        end else begin
            label_valid <= s2_v;
            if (s2_v) begin
                label    <= best_idx;
                min_dist <= best_dist;
            end
        end
        if (s2_v) s3_pt <= s2_pt;
    end

    // Saturating next values for the labelled cluster; a same-cycle clear zeroes the base
    always_comb begin
        logic [ACCUM_W-1:0] sum_base;
        logic [ACCUM_W:0]   sum_ext;
        logic [CNT_W-1:0]   cnt_base;
        logic [CNT_W:0]     cnt_ext;
        sat_any  = 1'b0;
        sum_base = '0;
        sum_ext  = '0;
        for (int d = 0; d < DIMS; d++) begin
            sum_base = accum_clear ? '0 : sum_q[label][d];
            sum_ext  = {1'b0, sum_base} + (ACCUM_W+1)'(s3_pt[d*COORD_W +: COORD_W]);
            if (sum_ext[ACCUM_W]) begin
                sum_nxt[d] = '1;
                sat_any    = 1'b1;
            end else begin
                sum_nxt[d] = sum_ext[ACCUM_W-1:0];
            end
        end
        cnt_base = accum_clear ? '0 : cnt_q[label];
        cnt_ext  = {1'b0, cnt_base} + (CNT_W+1)'(1);
        if (cnt_ext[CNT_W]) begin
            cnt_nxt = '1;
            sat_any = 1'b1;
        end else begin
            cnt_nxt = cnt_ext[CNT_W-1:0];
        end
    end

    // Accumulator bank: clear first, then the labelled update overrides its own cluster
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CENTROIDS; i++) begin
                cnt_q[i] <= '0;
                for (int d = 0; d < DIMS; d++) sum_q[i][d] <= '0;
            end
            ovf <= 1'b0;
        end else begin
            if (accum_clear) begin
                for (int i = 0; i < NUM_CENTROIDS; i++) begin
                    cnt_q[i] <= '0;
                    for (int d = 0; d < DIMS; d++) sum_q[i][d] <= '0;
                end
            end
            if (label_valid) begin
                cnt_q[label] <= cnt_nxt;
                for (int d = 0; d < DIMS; d++) sum_q[label][d] <= sum_nxt[d];
                if (sat_any) ovf <= 1'b1;
            end
        end
    end

    // Readout mux, dimension 0 in the LSBs
    always_comb begin
        for (int d = 0; d < DIMS; d++) rd_sum[d*ACCUM_W +: ACCUM_W] = sum_q[rd_idx][d];
        rd_cnt = cnt_q[rd_idx];
    end

endmodule

// File: tb/tb_kmeans_classify_core.sv
// Directed bench for kmeans_classify_core: one Manhattan instance and one
// squared-Euclidean instance share every input so both metrics see the
// same stimulus.
module tb_kmeans_classify_core;

    localparam int NUM_CENTROIDS = 8;
    localparam int DIMS          = 7;
    localparam int COORD_W       = 13;
    localparam int ACCUM_W       = 22;
    localparam int CNT_W         = 10;
    localparam int IDX_W         = 3;
    localparam int DIST_W        = COORD_W + 3;
    localparam int DIST_W_SQ     = 2 * COORD_W + 3;
    localparam int SUM_MAX       = (1 << ACCUM_W) - 1;
    localparam int CNT_MAX       = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- shared inputs ----------------
    logic [IDX_W:0]          k_active    = '0;
    logic                    cen_load    = 1'b0;
    logic [IDX_W-1:0]        cen_idx     = '0;
    logic [DIMS*COORD_W-1:0] cen_data    = '0;
    logic                    pt_valid    = 1'b0;
    logic [DIMS*COORD_W-1:0] pt_data     = '0;
    logic                    accum_clear = 1'b0;
    logic [IDX_W-1:0]        rd_idx      = '0;

    // ---------------- outputs, Manhattan ----------------
    logic                    pt_ready, label_valid, busy, ovf, cen_err;
    logic [IDX_W-1:0]        label;
    logic [DIST_W-1:0]       min_dist;
    logic [DIMS*ACCUM_W-1:0] rd_sum;
    logic [CNT_W-1:0]        rd_cnt;

    // ---------------- outputs, squared Euclidean ----------------
    logic                    pt_ready_sq, label_valid_sq, busy_sq, ovf_sq, cen_err_sq;
    logic [IDX_W-1:0]        label_sq;
    logic [DIST_W_SQ-1:0]    min_dist_sq;
    logic [DIMS*ACCUM_W-1:0] rd_sum_sq;
    logic [CNT_W-1:0]        rd_cnt_sq;

    kmeans_classify_core #(.DIST_MODE(0)) dut (
        .clk(clk), .rst(rst), .k_active(k_active),
        .cen_load(cen_load), .cen_idx(cen_idx), .cen_data(cen_data),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
        .accum_clear(accum_clear), .label_valid(label_valid), .label(label),
        .min_dist(min_dist), .rd_idx(rd_idx), .rd_sum(rd_sum), .rd_cnt(rd_cnt),
        .busy(busy), .ovf(ovf), .cen_err(cen_err)
    );

    kmeans_classify_core #(.DIST_MODE(1)) dut_sq (
        .clk(clk), .rst(rst), .k_active(k_active),
        .cen_load(cen_load), .cen_idx(cen_idx), .cen_data(cen_data),
        .pt_valid(pt_valid), .pt_ready(pt_ready_sq), .pt_data(pt_data),
        .accum_clear(accum_clear), .label_valid(label_valid_sq), .label(label_sq),
        .min_dist(min_dist_sq), .rd_idx(rd_idx), .rd_sum(rd_sum_sq), .rd_cnt(rd_cnt_sq),
        .busy(busy_sq), .ovf(ovf_sq), .cen_err(cen_err_sq)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DIMS*COORD_W-1:0] make_pt(input int v);
        logic [DIMS*COORD_W-1:0] r;
        r = '0;
        for (int d = 0; d < DIMS; d++) r[d*COORD_W +: COORD_W] = COORD_W'(v);
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        pt_valid = 1'b0;
        cen_load = 1'b0;
        accum_clear = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_cen(input int idx, input int v);
        cen_load = 1'b1;
        cen_idx  = IDX_W'(idx);
        cen_data = make_pt(v);
        tick();
        cen_load = 1'b0;
    endtask

    // Accept one point, wait (bounded) for its result, check it, end in cycle T+4
    task automatic classify(input string name, input int v, input int k,
                            input int exp_lbl, input int exp_d, input int exp_dsq);
        int n;
        k_active = (IDX_W+1)'(k);
        pt_valid = 1'b1;
        pt_data  = make_pt(v);
        tick();
        pt_valid = 1'b0;
        n = 1;
        while (!label_valid && n < 6) begin
            tick();
            n++;
        end
        check({name, "_latency"}, n, 3);
        check({name, "_label"}, label, exp_lbl);
        check({name, "_dist"}, min_dist, exp_d);
        check({name, "_label_sq"}, label_sq, exp_lbl);
        check({name, "_dist_sq"}, min_dist_sq, exp_dsq);
        tick();
    endtask

    task automatic send_stream(input int v, input int n);
        for (int i = 0; i < n; i++) begin
            pt_valid = 1'b1;
            pt_data  = make_pt(v);
            tick();
        end
        pt_valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic check_cluster(input string name, input int idx, input int exp_cnt, input int exp_lane);
        rd_idx = IDX_W'(idx);
        #1;
        check({name, "_cnt"}, rd_cnt, exp_cnt);
        check({name, "_cnt_sq"}, rd_cnt_sq, exp_cnt);
        for (int d = 0; d < DIMS; d++) begin
            check({name, "_sum"}, rd_sum[d*ACCUM_W +: ACCUM_W], exp_lane);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int pt_v;
        int k;
        int exp_lbl;
        int exp_d;
        int exp_dsq;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // c0 = 10, c1 = 100, slots 2..7 left at 0 from reset
        vecs[0] = '{pt_v: 12, k: 2,  exp_lbl: 0, exp_d: 14,  exp_dsq: 28};
        vecs[1] = '{pt_v: 60, k: 2,  exp_lbl: 1, exp_d: 280, exp_dsq: 11200};
        vecs[2] = '{pt_v: 55, k: 2,  exp_lbl: 0, exp_d: 315, exp_dsq: 14175};
        vecs[3] = '{pt_v: 90, k: 0,  exp_lbl: 0, exp_d: 560, exp_dsq: 44800};
        vecs[4] = '{pt_v: 90, k: 2,  exp_lbl: 1, exp_d: 70,  exp_dsq: 700};
        vecs[5] = '{pt_v: 3,  k: 8,  exp_lbl: 2, exp_d: 21,  exp_dsq: 63};
        vecs[6] = '{pt_v: 3,  k: 15, exp_lbl: 2, exp_d: 21,  exp_dsq: 63};
        vecs[7] = '{pt_v: 0,  k: 3,  exp_lbl: 2, exp_d: 0,   exp_dsq: 0};

        // ---- reset state ----
        do_reset();
        check("rst_pt_ready", pt_ready, 1);
        check("rst_label_valid", label_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_label", label, 0);
        check("rst_min_dist", min_dist, 0);
        check("rst_ovf", ovf, 0);
        check("rst_cen_err", cen_err, 0);
        check_cluster("rst_c0", 0, 0, 0);

        // ---- centroid load and single point ----
        load_cen(0, 10);
        load_cen(1, 100);
        classify("single", 12, 2, 0, 14, 28);
        check("single_busy_after", busy, 0);
        check("single_lv_after", label_valid, 0);
        check("single_label_hold", label, 0);
        check("single_dist_hold", min_dist, 14);
        check_cluster("single_c0", 0, 1, 12);

        // ---- table of classifications ----
        for (int i = 0; i < 8; i++) begin
            classify($sformatf("vec%0d", i), vecs[i].pt_v, vecs[i].k,
                     vecs[i].exp_lbl, vecs[i].exp_d, vecs[i].exp_dsq);
        end

        // ---- tie and k_active limit ----
        do_reset();
        load_cen(0, 5);
        load_cen(1, 5);
        load_cen(2, 6);
        classify("tie_k2", 6, 2, 0, 7, 7);
        classify("tie_k3", 6, 3, 2, 0, 0);

        // ---- streaming, both metrics ----
        do_reset();
        load_cen(0, 10);
        load_cen(1, 1000);
        k_active = 4'd2;
        for (int c = 0; c < 20; c++) begin
            pt_valid = (c < 16);
            pt_data  = make_pt((c % 2 == 0) ? 12 : 990);
            tick();
            if (c >= 2 && c <= 17) begin
                check("stream_lv", label_valid, 1);
                check("stream_lv_sq", label_valid_sq, 1);
                check("stream_label", label, (c - 2) % 2);
                check("stream_label_sq", label_sq, (c - 2) % 2);
                check("stream_dist_sq", min_dist_sq, ((c - 2) % 2 == 0) ? 28 : 700);
            end else begin
                check("stream_lv_idle", label_valid, 0);
            end
        end
        pt_valid = 1'b0;
        tick();
        check_cluster("stream_c0", 0, 8, 96);
        check_cluster("stream_c1", 1, 8, 7920);

        // ---- saturation ----
        do_reset();
        load_cen(0, 4000);
        k_active = 4'd1;
        send_stream(4000, 1000);
        check_cluster("sat_1000", 0, 1000, 4000000);
        check("sat_1000_ovf", ovf, 0);
        send_stream(4000, 23);
        check_cluster("sat_1023", 0, CNT_MAX, 4092000);
        check("sat_1023_ovf", ovf, 0);
        send_stream(4000, 77);
        check_cluster("sat_1100", 0, CNT_MAX, SUM_MAX);
        check("sat_1100_ovf", ovf, 1);
        check("sat_1100_ovf_sq", ovf_sq, 1);
        accum_clear = 1'b1;
        tick();
        accum_clear = 1'b0;
        check_cluster("sat_clear", 0, 0, 0);
        check("sat_clear_ovf", ovf, 1);

        // ---- accum_clear coinciding with label_valid ----
        send_stream(4000, 3);
        check_cluster("pre_clr", 0, 3, 12000);
        pt_valid = 1'b1;
        pt_data  = make_pt(4000);
        tick();
        pt_valid = 1'b0;
        tick();
        tick();
        check("clr_lv", label_valid, 1);
        accum_clear = 1'b1;
        tick();
        accum_clear = 1'b0;
        check_cluster("clr_coincide", 0, 1, 4000);

        // ---- centroid write while busy ----
        pt_valid = 1'b1;
        pt_data  = make_pt(4000);
        tick();
        pt_valid = 1'b0;
        check("cenbusy_busy", busy, 1);
        check("cenbusy_err_before", cen_err, 0);
        cen_load = 1'b1;
        cen_idx  = '0;
        cen_data = make_pt(50);
        #1;
        check("cenbusy_ready", pt_ready, 0);
        tick();
        cen_load = 1'b0;
        check("cenbusy_err", cen_err, 1);
        check("cenbusy_err_sq", cen_err_sq, 1);
        repeat (3) tick();
        classify("cenbusy_unchanged", 4000, 1, 0, 0, 0);

        // ---- reset in mid-operation ----
        do_reset();
        check("midrst_cen_err", cen_err, 0);
        k_active = 4'd1;
        pt_valid = 1'b1;
        pt_data  = make_pt(7);
        tick();
        pt_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_lv", label_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_lv_later", label_valid, 0);
        end
        check_cluster("midrst_c0", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
